// File: rtl/stream_mux.sv
// stream_mux: N-to-1 stream multiplexer with a registered output stage.
// One valid input channel is granted per cycle; the granted word is captured
// into the output register whenever that register is empty or being drained.
// Build option: define STREAM_MUX_RR_EN for round-robin arbitration; otherwise
// fixed priority where the lowest valid index wins.

module stream_mux #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 8,
   localparam int unsigned SELW  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic [NUM_IN-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SELW-1:0]         out_sel,
   input  logic                    out_ready
);

   logic             load;
   logic             gnt_found;
   logic [SELW-1:0]  gnt_idx;
   logic [SELW-1:0]  ptr;
   // One extra bit so ptr + offset cannot overflow before the wrap.
   logic [SELW:0]    cand;
   logic [WIDTH-1:0] chan [NUM_IN];

   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [SELW-1:0]  sel_q;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
      assign chan[i] = in_data[i*WIDTH +: WIDTH];
   end

   assign load      = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sel   = sel_q;

   // Grant: first valid channel found scanning upward from ptr, with wrap.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         cand = {1'b0, ptr} + (SELW+1)'(k);
         if (cand >= (SELW+1)'(NUM_IN)) begin
            cand = cand - (SELW+1)'(NUM_IN);
         end
         if (!gnt_found && in_valid[cand[SELW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[SELW-1:0];
         end
      end
   end

   // Ready is the grant qualified by load; forced low while in reset.
   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         in_ready[i] = gnt_found && (gnt_idx == SELW'(i)) && load && !reset;
      end
   end

   // Output register: capture on load with a grant, empty on load without one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else if (load) begin
         valid_q <= gnt_found;
         if (gnt_found) begin
            data_q <= chan[gnt_idx];
            sel_q  <= gnt_idx;
         end
      end
   end

`ifdef STREAM_MUX_RR_EN
   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] ptr_d;

   // Advance the search start to just past the channel that was captured.
   always_comb begin
      ptr_d = ptr_q;
      if (load && gnt_found) begin
         ptr_d = (gnt_idx == SELW'(NUM_IN - 1)) ? '0 : gnt_idx + SELW'(1);
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

endmodule
